// File: rtl/rgb_led_scheduler_pkg.sv
// led_pkg: display modes, RGB channel offsets and one-hot mode indicator encodings
package led_pkg;
  typedef enum logic [1:0] {OFF, STATIC, BREATHE, CHASE} mode_e;
  localparam int R_OFS = 0;
  localparam int G_OFS = 1;
  localparam int B_OFS = 2;
  localparam int NUM_RGB = 4;
  localparam logic [3:0] LED_OFF = 4'b0001;
  localparam logic [3:0] LED_STATIC = 4'b0010;
  localparam logic [3:0] LED_BREATHE = 4'b0100;
  localparam logic [3:0] LED_CHASE = 4'b1000;
  function automatic logic [3:0] mode_led(mode_e m);
    return m == OFF ? LED_OFF : m == STATIC ? LED_STATIC : m == BREATHE ? LED_BREATHE : LED_CHASE;
  endfunction
endpackage

// File: rtl/rgb_led_scheduler_tick_gen.sv
// tick_gen: animation tick (sclk, resetn, clr restarts, slow passes every 4th tick) -> tick pulse
module tick_gen #(
  parameter int TICK_DIV = 390625
) (
  input  logic sclk,
  input  logic resetn,
  input  logic clr,
  input  logic slow,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] pre_q;
  logic [1:0] sub_q;
  logic raw;
  assign raw = pre_q == W'(TICK_DIV - 1);
  assign tick = raw & (~slow | sub_q == 2'd3);
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
      sub_q <= '0;
    end else if (clr) begin
      pre_q <= '0;
      sub_q <= '0;
    end else begin
      pre_q <= raw ? '0 : pre_q + W'(1);
      sub_q <= raw ? sub_q + 2'd1 : sub_q;
    end
  end
endmodule

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: button-driven mode/brightness control and shared-counter PWM (sclk, resetn, sw, btn -> led one-hot, rgb_out 12 channels)
module rgb_led_scheduler
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 390625,
  parameter int BRIGHT_STEP = 32,
  parameter int BRIGHT_RST = 128
) (
  input  logic                   sclk,
  input  logic                   resetn,
  input  logic [3:0]             sw,
  input  logic [3:0]             btn,
  output logic [3:0]             led,
  output logic [3*NUM_RGB-1:0]   rgb_out
);
  mode_e mode_q, mode_d;
  logic [3:0] btn_q, press;
  logic [PWM_BITS-1:0] bright_q, bright_d, pwm_q, level_q, breathe_duty;
  logic [PWM_BITS:0] up_sum, dn_diff;
  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0] led_duty [NUM_RGB];
  logic [3*NUM_RGB-1:0] rgb_d;
  logic [1:0] pos_q;
  logic dir_q, nxt, prv, chg, tick;
  assign press = btn & ~btn_q;
  assign nxt = press[0] & ~press[1];
  assign prv = press[1] & ~press[0];
  assign chg = nxt | prv;
  assign mode_d = nxt ? mode_e'(mode_q + 2'd1) : prv ? mode_e'(mode_q - 2'd1) : mode_q;
  assign up_sum = {1'b0, bright_q} + (PWM_BITS+1)'(BRIGHT_STEP);
  // both operands are below 2^PWM_BITS, so the top bit of the difference is the borrow
  assign dn_diff = {1'b0, bright_q} - (PWM_BITS+1)'(BRIGHT_STEP);
  assign bright_d = (press[2] & ~press[3]) ? (up_sum[PWM_BITS] ? '1 : up_sum[PWM_BITS-1:0]) :
                    (press[3] & ~press[2]) ? (dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0]) : bright_q;
  assign prod = (2*PWM_BITS)'(level_q) * (2*PWM_BITS)'(bright_q);
  assign breathe_duty = prod[2*PWM_BITS-1:PWM_BITS];
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sclk(sclk), .resetn(resetn), .clr(chg), .slow(sw[3]), .tick(tick)
  );
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < NUM_RGB; i++) begin
      led_duty[i] = mode_q == STATIC ? bright_q : mode_q == BREATHE ? breathe_duty :
                    (mode_q == CHASE && pos_q == 2'(i)) ? bright_q : '0;
      rgb_d[3*i+R_OFS] = sw[0] & (pwm_q < led_duty[i]);
      rgb_d[3*i+G_OFS] = sw[1] & (pwm_q < led_duty[i]);
      rgb_d[3*i+B_OFS] = sw[2] & (pwm_q < led_duty[i]);
    end
  end
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= OFF;
      led <= LED_OFF;
      btn_q <= 4'b1111;
      bright_q <= PWM_BITS'(BRIGHT_RST);
      pwm_q <= '0;
      level_q <= '0;
      dir_q <= 1'b0;
      pos_q <= '0;
      rgb_out <= '0;
    end else begin
      btn_q <= btn;
      mode_q <= mode_d;
      led <= mode_led(mode_d);
      bright_q <= bright_d;
      pwm_q <= pwm_q + PWM_BITS'(1);
      rgb_out <= rgb_d;
      if (chg) begin
        level_q <= '0;
        dir_q <= 1'b0;
        pos_q <= '0;
      end else if (tick) begin
        // dir_q = 1 means counting down; the endpoints bounce so 255 is followed by 254
        if (mode_q == BREATHE) begin
          level_q <= dir_q ? (level_q == '0 ? PWM_BITS'(1) : level_q - PWM_BITS'(1)) :
                             (level_q == '1 ? level_q - PWM_BITS'(1) : level_q + PWM_BITS'(1));
          dir_q <= dir_q ? (level_q != '0) : (level_q == '1);
        end
        if (mode_q == CHASE) pos_q <= pos_q + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_scheduler.sv
// tb_rgb_led_scheduler: scoreboard bench for mode stepping, brightness saturation, PWM duty, animations and async reset
module tb_rgb_led_scheduler;
  logic sclk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] btn = '0;
  logic [3:0] led;
  logic [11:0] rgb_out;
  int n_chk = 0;
  int n_fail = 0;
  int bm = 128;
  typedef struct {string tag; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  rgb_led_scheduler #(.TICK_DIV(4)) dut (
    .sclk(sclk), .resetn(resetn), .sw(sw), .btn(btn), .led(led), .rgb_out(rgb_out)
  );
  always #5 sclk = ~sclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask
  task automatic sb_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0h with no expected value queued", got);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask
  task automatic press(input logic [3:0] m);
    @(negedge sclk) btn = m;
    @(negedge sclk) btn = '0;
  endtask
  task automatic measure(output int hi, output int other, output int skew);
    hi = 0;
    other = 0;
    skew = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sclk);
      hi += int'(rgb_out[0]);
      other += int'(|(rgb_out & 12'hDB6));
      skew += int'(rgb_out[3] != rgb_out[0]) + int'(rgb_out[6] != rgb_out[0]) + int'(rgb_out[9] != rgb_out[0]);
    end
  endtask
  task automatic bright_step(input logic [3:0] m, input string tag);
    int hi, other, skew;
    press(m);
    if (m == 4'b0100) bm = (bm + 32 > 255) ? 255 : bm + 32;
    if (m == 4'b1000) bm = (bm - 32 < 0) ? 0 : bm - 32;
    sb_push(tag, bm);
    repeat (2) @(negedge sclk);
    measure(hi, other, skew);
    sb_check(hi);
  endtask
  task automatic chase_run(input int period);
    logic [11:0] a;
    for (int k = 0; k < 5; k++) sb_push("chase_pos", 32'(12'h007 << (3 * (k % 4))));
    repeat (2) @(negedge sclk);
    for (int k = 0; k < 5; k++) begin
      a = rgb_out;
      @(negedge sclk);
      sb_check(32'(a | rgb_out));
      repeat (period - 1) @(negedge sclk);
    end
  endtask
  initial begin
    int hi, other, skew, n;
    logic [11:0] a;
    btn = 4'b0001;
    repeat (3) @(negedge sclk);
    resetn = 1'b1;
    repeat (3) @(negedge sclk);
    chk("rst_led", 32'(led), 32'h1);
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    btn = '0;
    @(negedge sclk) btn = 4'b0001;
    #1 chk("pre_edge_led", 32'(led), 32'h1);
    @(negedge sclk) btn = '0;
    chk("static_led", 32'(led), 32'h2);
    sw = 4'b0001;
    repeat (3) @(negedge sclk);
    measure(hi, other, skew);
    chk("static_r_hi", 32'(hi), 32'd128);
    chk("static_gb_off", 32'(other), 32'd0);
    chk("r_lockstep", 32'(skew), 32'd0);
    repeat (5) bright_step(4'b0100, "bright_up");
    repeat (9) bright_step(4'b1000, "bright_dn");
    bright_step(4'b1100, "bright_both_at0");
    bright_step(4'b0100, "bright_up");
    bright_step(4'b1100, "bright_both");
    repeat (3) bright_step(4'b0100, "bright_up");
    press(4'b0001);
    chk("breathe_led", 32'(led), 32'h4);
    n = 0;
    while (n < 2000 && dut.level_q != 8'd255) begin
      @(negedge sclk);
      n++;
    end
    chk("breathe_cycles_to_255", 32'(n), 32'd1020);
    chk("breathe_duty_255", 32'(dut.breathe_duty), 32'd127);
    repeat (4) @(negedge sclk);
    chk("breathe_turn", 32'(dut.level_q), 32'd254);
    repeat (4) press(4'b0100);
    sw = 4'b0111;
    press(4'b0001);
    chk("chase_led", 32'(led), 32'h8);
    chase_run(4);
    sw = 4'b1111;
    press(4'b0010);
    press(4'b0001);
    chase_run(16);
    press(4'b0011);
    chk("both_mode_nochange", 32'(led), 32'h8);
    press(4'b0001);
    chk("wrap_to_off", 32'(led), 32'h1);
    repeat (3) @(negedge sclk);
    chk("off_rgb", 32'(rgb_out), 32'h0);
    press(4'b0010);
    chk("prev_wrap_chase", 32'(led), 32'h8);
    repeat (2) @(negedge sclk);
    a = rgb_out;
    @(negedge sclk);
    chk("pre_rst_lit", 32'(|(a | rgb_out)), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rgb", 32'(rgb_out), 32'h0);
    chk("async_led", 32'(led), 32'h1);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    repeat (2) @(negedge sclk);
    resetn = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
